// File: rtl/hilo_muldiv.sv
// hilo_muldiv: HI/LO register file with multu capture, mthi/mtlo and an
// iterative restoring divider. The divider is built only when the macro
// HILO_MULDIV_DIV_EN is defined; otherwise op 4/5 are no-ops and busy/dz are 0.
module hilo_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [2:0]  op,
    input  logic [31:0] alu_lo,
    input  logic [31:0] alu_hi,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        dz
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 5;

    localparam logic [2:0] OP_MULT_WR = 3'd1;
    localparam logic [2:0] OP_MTHI    = 3'd2;
    localparam logic [2:0] OP_MTLO    = 3'd3;
    localparam logic [2:0] OP_DIV     = 3'd4;
    localparam logic [2:0] OP_DIVU    = 3'd5;

    logic [W-1:0] hi_nxt;
    logic [W-1:0] lo_nxt;

`ifdef HILO_MULDIV_DIV_EN

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]    state,  state_nxt;
    logic [CW-1:0] cnt,    cnt_nxt;
    logic [W:0]    prem,   prem_nxt;   // 33-bit partial remainder
    logic [W-1:0]  qd,     qd_nxt;     // dividend bits out, quotient bits in
    logic [W-1:0]  dvs,    dvs_nxt;    // divisor magnitude
    logic          qsign,  qsign_nxt;
    logic          rsign,  rsign_nxt;
    logic          zflag,  zflag_nxt;
    logic          busy_nxt;
    logic          dz_nxt;

    logic          accept;
    logic          is_div;
    logic [W:0]    pr_sh;
    logic [W:0]    diff;
    logic [W-1:0]  q_fix;
    logic [W-1:0]  r_fix;

    // Command accept qualifier and one restoring-division step
    always_comb begin
        accept = en && !busy && (op >= OP_MULT_WR) && (op <= OP_DIVU);
        is_div = (op == OP_DIV);
        pr_sh  = {prem[W-1:0], qd[W-1]};
        diff   = pr_sh - {1'b0, dvs};
        q_fix  = qsign ? W'(-qd) : qd;
        r_fix  = rsign ? W'(-prem[W-1:0]) : prem[W-1:0];
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        prem_nxt  = prem;
        qd_nxt    = qd;
        dvs_nxt   = dvs;
        qsign_nxt = qsign;
        rsign_nxt = rsign;
        zflag_nxt = zflag;
        busy_nxt  = busy;
        dz_nxt    = 1'b0;
        hi_nxt    = hi;
        lo_nxt    = lo;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_MULT_WR: begin
                            hi_nxt = alu_hi;
                            lo_nxt = alu_lo;
                        end
                        OP_MTHI: hi_nxt = a;
                        OP_MTLO: lo_nxt = a;
                        default: begin
                            // DIV or DIVU
                            qd_nxt    = (is_div && a[W-1]) ? W'(-a) : a;
                            dvs_nxt   = (is_div && b[W-1]) ? W'(-b) : b;
                            qsign_nxt = is_div && (a[W-1] ^ b[W-1]);
                            rsign_nxt = is_div && a[W-1];
                            zflag_nxt = (b == '0);
                            prem_nxt  = '0;
                            cnt_nxt   = '0;
                            busy_nxt  = 1'b1;
                            state_nxt = S_RUN;
                        end
                    endcase
                end
            end
            S_RUN: begin
                if (!diff[W]) begin
                    prem_nxt = diff;
                    qd_nxt   = {qd[W-2:0], 1'b1};
                end else begin
                    prem_nxt = pr_sh;
                    qd_nxt   = {qd[W-2:0], 1'b0};
                end
                cnt_nxt = cnt + CW'(1);
                if (cnt == CW'(W - 1)) begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                lo_nxt    = zflag ? '1 : q_fix;
                hi_nxt    = r_fix;
                dz_nxt    = zflag;
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end
            default: begin
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any division in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            prem  <= '0;
            qd    <= '0;
            dvs   <= '0;
            qsign <= 1'b0;
            rsign <= 1'b0;
            zflag <= 1'b0;
            busy  <= 1'b0;
            dz    <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            prem  <= prem_nxt;
            qd    <= qd_nxt;
            dvs   <= dvs_nxt;
            qsign <= qsign_nxt;
            rsign <= rsign_nxt;
            zflag <= zflag_nxt;
            busy  <= busy_nxt;
            dz    <= dz_nxt;
            hi    <= hi_nxt;
            lo    <= lo_nxt;
        end
    end

`else

    logic unused_b;

    // Divisor operand has no consumer without the divider
    assign unused_b = ^b;
    assign busy     = 1'b0;
    assign dz       = 1'b0;

    // HI/LO writes from multu capture and mthi/mtlo
    always_comb begin
        hi_nxt = hi;
        lo_nxt = lo;
        if (en) begin
            case (op)
                OP_MULT_WR: begin
                    hi_nxt = alu_hi;
                    lo_nxt = alu_lo;
                end
                OP_MTHI: hi_nxt = a;
                OP_MTLO: lo_nxt = a;
                default: begin
                    hi_nxt = hi;
                    lo_nxt = lo;
                end
            endcase
        end
    end

    // HI/LO registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else begin
            hi <= hi_nxt;
            lo <= lo_nxt;
        end
    end

`endif

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv; expectations adapt to whether the divider
// (HILO_MULDIV_DIV_EN) is built.
module tb_hilo_muldiv;

    logic        clk;
    logic        rst;
    logic        en;
    logic [2:0]  op;
    logic [31:0] alu_lo;
    logic [31:0] alu_hi;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        dz;

    int          n_vec;
    int          n_err;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    hilo_muldiv dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .op     (op),
        .alu_lo (alu_lo),
        .alu_hi (alu_hi),
        .a      (a),
        .b      (b),
        .hi     (hi),
        .lo     (lo),
        .busy   (busy),
        .dz     (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Single-cycle command presented for one rising edge
    task automatic do_cmd(input logic [2:0] cop, input logic [31:0] ca,
                          input logic [31:0] chi, input logic [31:0] clo);
        @(negedge clk);
        en = 1'b1; op = cop; a = ca; alu_hi = chi; alu_lo = clo;
        @(negedge clk);
        en = 1'b0; op = 3'd0;
    endtask

    // Division with busy-length, result and dz checks; optional MTLO while busy
    task automatic do_div(input string tag, input logic [2:0] dop,
                          input logic [31:0] da, input logic [31:0] db,
                          input logic [31:0] eq, input logic [31:0] er,
                          input logic edz, input bit inj);
        int          cyc;
        int          ecyc;
        logic [31:0] xq;
        logic [31:0] xr;
        logic        xdz;
`ifdef HILO_MULDIV_DIV_EN
        ecyc = 33; xq = eq; xr = er; xdz = edz;
`else
        ecyc = 0; xq = m_lo; xr = m_hi; xdz = 1'b0;
`endif
        @(negedge clk);
        en = 1'b1; op = dop; a = da; b = db;
        @(negedge clk);
        en = 1'b0; op = 3'd0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            if (cyc == 1) chk({tag, "_hold_lo"}, lo, m_lo);
            if (inj && cyc == 5) begin
                en = 1'b1; op = 3'd3; a = 32'd5;
            end else begin
                en = 1'b0; op = 3'd0;
            end
            cyc++;
            @(negedge clk);
        end
        en = 1'b0; op = 3'd0;
        chk({tag, "_busy_cycles"}, 32'(cyc), 32'(ecyc));
        chk({tag, "_lo"}, lo, xq);
        chk({tag, "_hi"}, hi, xr);
        chk({tag, "_dz"}, 32'(dz), 32'(xdz));
        @(negedge clk);
        chk({tag, "_dz_pulse"}, 32'(dz), 32'd0);
        m_lo = xq;
        m_hi = xr;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst = 1'b1; en = 1'b0; op = 3'd0;
        alu_lo = '0; alu_hi = '0; a = '0; b = '0;
        m_hi = '0; m_lo = '0;

        repeat (2) @(negedge clk);
        chk("rst_hi",   hi, 32'h0);
        chk("rst_lo",   lo, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dz",   32'(dz), 32'd0);
        rst = 1'b0;

        // multu capture of 0xFFFFFFFF * 2
        do_cmd(3'd1, 32'h0, 32'h0000_0001, 32'hFFFF_FFFE);
        chk("mult_hi",   hi, 32'h0000_0001);
        chk("mult_lo",   lo, 32'hFFFF_FFFE);
        chk("mult_busy", 32'(busy), 32'd0);

        do_cmd(3'd2, 32'hDEAD_BEEF, 32'h0, 32'h0);
        chk("mthi_hi", hi, 32'hDEAD_BEEF);
        chk("mthi_lo", lo, 32'hFFFF_FFFE);
        do_cmd(3'd3, 32'h1234_5678, 32'h0, 32'h0);
        chk("mtlo_lo", lo, 32'h1234_5678);
        chk("mtlo_hi", hi, 32'hDEAD_BEEF);
        m_hi = 32'hDEAD_BEEF; m_lo = 32'h1234_5678;

        // reserved op and disabled command leave state alone
        do_cmd(3'd6, 32'hAAAA_AAAA, 32'h1, 32'h2);
        chk("rsv_hi", hi, 32'hDEAD_BEEF);
        chk("rsv_lo", lo, 32'h1234_5678);
        @(negedge clk);
        en = 1'b0; op = 3'd4; a = 32'd10; b = 32'd2;
        @(negedge clk);
        op = 3'd0;
        chk("noen_busy", 32'(busy), 32'd0);
        chk("noen_lo", lo, 32'h1234_5678);

        do_div("div_m7_2",  3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_div("div_7_m2",  3'd4, 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, 1'b0, 1'b0);
        do_div("divu_100_7",3'd5, 32'd100,      32'd7,         32'd14,        32'd2,         1'b0, 1'b1);
        do_div("divu_z",    3'd5, 32'h55,       32'd0,         32'hFFFF_FFFF, 32'h55,        1'b1, 1'b0);
        do_div("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0,        1'b0, 1'b0);
        do_div("divu_big",  3'd5, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 1'b0);
        do_div("div_z_neg", 3'd4, 32'hFFFF_FF9C, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FF9C, 1'b1, 1'b0);

        // reset in the middle of a division
        @(negedge clk);
        en = 1'b1; op = 3'd4; a = 32'h0000_1000; b = 32'd3;
        @(negedge clk);
        en = 1'b0; op = 3'd0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_hi",   hi, 32'h0);
        chk("mid_rst_lo",   lo, 32'h0);
        chk("mid_rst_dz",   32'(dz), 32'd0);
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        rst = 1'b0;
        do_div("divu_9_3", 3'd5, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
